// File: rtl/lutram16_loader_pkg.sv
// Shared definitions for the 16x1 LUT-RAM loader macro test.
//   DEPTH   : number of RAM locations (RAM16X1S geometry)
//   AW      : address width, log2(DEPTH)
//   state_e : loader FSM states, 2-bit encoding
package lutram_pkg;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/lutram16_loader_ram.sv
// Behavioural 16x1 distributed RAM, drop-in stand-in for a RAM16X1S cell.
// Synchronous write, asynchronous read, no reset on the array.
//   clk_i  : write clock
//   we_i   : write enable, data captured on rising edge
//   addr_i : shared read/write address
//   d_i    : write data
//   q_o    : asynchronous read data, mem[addr_i]
module ram16x1_sync #(
    parameter int unsigned DEPTH = lutram_pkg::DEPTH,
    parameter int unsigned AW    = lutram_pkg::AW
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          d_i,
    output logic          q_o
);

    logic mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= d_i;
        end
    end

    assign q_o = mem[addr_i];

endmodule

// File: rtl/lutram16_loader.sv
// Loads a 16-bit pattern into a 16x1 LUT RAM one bit per cycle, optionally
// reads every location back to flag mismatches, then serves external reads.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : load request, sampled only in IDLE
//   wdata : pattern to load, bit n -> address n
//   raddr : external read address, used only in IDLE
//   rdata : external read data (combinational, forced 0 while busy)
//   busy  : high from the cycle after start is accepted until DONE exits
//   done  : one-cycle completion pulse
//   err   : sticky verify-mismatch flag, cleared on the next accepted start
module lutram16_loader #(
    parameter int unsigned DEPTH  = lutram_pkg::DEPTH,
    parameter int unsigned AW     = lutram_pkg::AW,
    parameter int unsigned VERIFY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DEPTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic             rdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import lutram_pkg::state_e;
    import lutram_pkg::ST_IDLE;
    import lutram_pkg::ST_WRITE;
    import lutram_pkg::ST_VERIFY;
    import lutram_pkg::ST_DONE;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic             ram_d;
    logic             ram_q;

    // Write data is always the shadow bit at the current count; only ram_we
    // decides whether it lands in the array.
    assign ram_d = shadow_q[cnt_q];

    ram16x1_sync #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .d_i    (ram_d),
        .q_o    (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        ram_we   = 1'b0;
        ram_addr = raddr;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d = wdata;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we   = 1'b1;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = (VERIFY != 0) ? ST_VERIFY : ST_DONE;
                end
            end
            ST_VERIFY: begin
                ram_addr = cnt_q;
                if (ram_q != shadow_q[cnt_q]) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered flags follow the next state so busy rises the cycle
        // after acceptance and drops exactly as done is presented.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    assign rdata = busy_q ? 1'b0 : ram_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_lutram16_loader.sv
module tb_lutram16_loader;

    logic        clk;
    logic        rst_n;
    logic        start1, start0;
    logic [15:0] wdata;
    logic [3:0]  raddr;
    logic        rdata1, busy1, done1, err1;
    logic        rdata0, busy0, done0, err0;

    int n_tests = 0;
    int n_fail  = 0;

    lutram16_loader #(.DEPTH(16), .AW(4), .VERIFY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata1),
        .busy  (busy1),
        .done  (done1),
        .err   (err1)
    );

    lutram16_loader #(.DEPTH(16), .AW(4), .VERIFY(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata0),
        .busy  (busy0),
        .done  (done0),
        .err   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse, then 40 post-edge samples. Sample i is taken
    // 1ns after edge k+i, where k is the accepting edge.
    // inj 1: second start with 16'hffff sampled at edge k+5
    // inj 2: RAM write data forced low for the address-5 write (edge k+6)
    task automatic do_load(input bit sel, input logic [15:0] pat, input int inj,
                           output int busy_cnt, output int done_at, output int done_cnt,
                           output logic err_first, output logic err_at_done);
        logic b, d, e;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        wdata = pat;
        tick();
        start1 = 1'b0;
        start0 = 1'b0;
        busy_cnt    = 0;
        done_at     = -1;
        done_cnt    = 0;
        err_at_done = 1'bx;
        err_first   = sel ? err1 : err0;
        for (int i = 0; i < 40; i++) begin
            if (inj == 1 && i == 4) begin start1 = 1'b1; wdata = 16'hffff; end
            if (inj == 1 && i == 5) start1 = 1'b0;
            if (inj == 2 && i == 5) force dut1.ram_d = 1'b0;
            if (inj == 2 && i == 6) release dut1.ram_d;
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            e = sel ? err1  : err0;
            if (b === 1'b1) busy_cnt++;
            if (d === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at     = i;
                    err_at_done = e;
                end
            end
            tick();
        end
    endtask

    task automatic readback(input bit sel, input logic [15:0] pat, input string tag);
        for (int i = 0; i < 16; i++) begin
            raddr = 4'(i);
            #1;
            chk($sformatf("%s[%0d]", tag, i), {31'd0, (sel ? rdata1 : rdata0)}, {31'd0, pat[i]});
        end
    endtask

    int   bc, da, dc;
    logic ef, ed;

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        wdata  = '0;
        raddr  = '0;

        // reset / idle
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);
        chk("rst_err1",  {31'd0, err1},  32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_err0",  {31'd0, err0},  32'd0);

        // basic load, verify enabled
        do_load(1'b1, 16'habcd, 0, bc, da, dc, ef, ed);
        chk("v1_busy_cycles", 32'(bc), 32'd33);
        chk("v1_done_at",     32'(da), 32'd33);
        chk("v1_done_count",  32'(dc), 32'd1);
        chk("v1_err",         {31'd0, ed}, 32'd0);
        readback(1'b1, 16'habcd, "v1_rd");

        // verify disabled build
        do_load(1'b0, 16'h8001, 0, bc, da, dc, ef, ed);
        chk("v0_busy_cycles", 32'(bc), 32'd17);
        chk("v0_done_at",     32'(da), 32'd17);
        chk("v0_done_count",  32'(dc), 32'd1);
        chk("v0_err",         {31'd0, ed}, 32'd0);
        readback(1'b0, 16'h8001, "v0_rd");

        // start during a load is ignored
        do_load(1'b1, 16'habcd, 1, bc, da, dc, ef, ed);
        chk("ign_done_at",    32'(da), 32'd33);
        chk("ign_done_count", 32'(dc), 32'd1);
        chk("ign_busy_cycles", 32'(bc), 32'd33);
        readback(1'b1, 16'habcd, "ign_rd");

        // asynchronous reset mid-load
        wdata  = 16'h0f0f;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        chk("mid_busy_before", {31'd0, busy1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy",  {31'd0, busy1}, 32'd0);
        chk("mid_done",  {31'd0, done1}, 32'd0);
        chk("mid_state", 32'(dut1.state_q), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_load(1'b1, 16'h1234, 0, bc, da, dc, ef, ed);
        chk("post_rst_done_at", 32'(da), 32'd33);
        chk("post_rst_err",     {31'd0, ed}, 32'd0);
        readback(1'b1, 16'h1234, "post_rst_rd");

        // fault injection at address 5
        do_load(1'b1, 16'hffff, 2, bc, da, dc, ef, ed);
        chk("flt_done_at", 32'(da), 32'd33);
        chk("flt_err",     {31'd0, ed}, 32'd1);
        repeat (5) tick();
        chk("flt_err_sticky", {31'd0, err1}, 32'd1);
        raddr = 4'd5;
        #1;
        chk("flt_rd5", {31'd0, rdata1}, 32'd0);

        // clean load clears err on acceptance
        do_load(1'b1, 16'h5a5a, 0, bc, da, dc, ef, ed);
        chk("clr_err_accept", {31'd0, ef}, 32'd0);
        chk("clr_err_done",   {31'd0, ed}, 32'd0);
        chk("clr_done_count", 32'(dc), 32'd1);
        readback(1'b1, 16'h5a5a, "clr_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
